time_step_counter: RTL and testbench



---
 rtl/time_step_pkg.sv | 17 +
 rtl/time_step_counter_reset_sync.sv | 25 ++
 rtl/time_step_counter.sv | 104 ++++++++++
 tb/tb_time_step_counter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/time_step_pkg.sv
// Shared types and helpers for the lattice time-step counter.
package time_step_pkg;

    // Counter FSM states: no step taken yet, stepping, terminal count reached.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        DONE     = 2'd2
    } ts_state_e;

    // The count carries one extra bit over the base width so that MAX_TIME
    // itself is representable even when it is a power of two.
    function automatic int count_width(input int base_w);
        return base_w + 1;
    endfunction

endpackage

// File: rtl/time_step_counter_reset_sync.sv
// Two-flop reset synchronizer: asserts immediately, releases on the second
// rising clock edge after the raw reset falls.
module reset_sync (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_rst
);

    logic r_meta;
    logic r_sync;

    // Shift a deasserted level through two flops; any raw assert clears both at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= 1'b0;
            r_sync <= r_meta;
        end
    end

    assign o_rst = r_sync;

endmodule

// File: rtl/time_step_counter.sv
// Saturating lattice time-step counter: one step per enabled clock edge,
// holding at MAX_TIME until reset.
module time_step_counter
    import time_step_pkg::*;
#(
    parameter int MAX_TIME         = 100,
    parameter int TIME_COUNT_WIDTH = $clog2(MAX_TIME)
) (
    input  logic                                       Clk,
    input  logic                                       Reset,
    input  logic                                       Enable,
    output logic [count_width(TIME_COUNT_WIDTH)-1:0]   Data_out
);

    localparam int           CW    = count_width(TIME_COUNT_WIDTH);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_TIME);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    logic          w_rst;
    ts_state_e     r_state;
    ts_state_e     w_state_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic [CW-1:0] w_count_inc;

    // Raw Reset asserts straight through; its release is aligned to Clk.
    reset_sync u_reset_sync (
        .i_clk (Clk),
        .i_rst (Reset),
        .o_rst (w_rst)
    );

    assign w_count_inc = r_count + ONE_C;

    // State and count registers; cleared asynchronously by the synchronized reset.
    always_ff @(posedge Clk or posedge w_rst) begin
        if (w_rst) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Next-state and next-count: the increment only happens below MAX_TIME,
    // so the count can never wrap.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            IDLE: begin
                if (Enable) begin
                    w_count_nxt = ONE_C;
                    w_state_nxt = (ONE_C == MAX_C) ? DONE : COUNTING;
                end
            end
            COUNTING: begin
                if (Enable) begin
                    w_count_nxt = w_count_inc;
                    if (w_count_inc == MAX_C) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_count_nxt = MAX_C;
            end
            default: begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    assign Data_out = r_count;

`ifndef SYNTHESIS
    logic [CW-1:0] r_prev;
    logic          r_prev_vld;

    // Output never exceeds the terminal count.
    a_max : assert property (@(posedge Clk) Data_out <= MAX_C)
        else $error("Data_out above MAX_TIME");

    // Compare each sampled output with the previous one; history is dropped on reset.
    always @(posedge Clk or posedge w_rst) begin
        if (w_rst) begin
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
        end else begin
            if (r_prev_vld) begin
                a_no_dec : assert (Data_out >= r_prev)
                    else $error("Data_out decremented without reset");
                a_step1 : assert ((Data_out - r_prev) <= ONE_C)
                    else $error("Data_out advanced by more than one");
            end
            r_prev     <= Data_out;
            r_prev_vld <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_time_step_counter.sv
// Bench for time_step_counter: directed plan plus randomized enable/reset
// traffic, checked against a saturating-integer model.
module tb_time_step_counter;
    import time_step_pkg::*;

    localparam int MAX_A = 100;
    localparam int MAX_B = 64;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       en_a;
    logic       en_b;
    logic [7:0] dout_a;
    logic [7:0] dout_b;

    int n_chk  = 0;
    int n_fail = 0;
    int m_a    = 0;
    int m_b    = 0;

    always #10 Clk = ~Clk;

    time_step_counter #(.MAX_TIME(MAX_A)) dut_a (
        .Clk      (Clk),
        .Reset    (Reset),
        .Enable   (en_a),
        .Data_out (dout_a)
    );

    time_step_counter #(.MAX_TIME(MAX_B), .TIME_COUNT_WIDTH(7)) dut_b (
        .Clk      (Clk),
        .Reset    (Reset),
        .Enable   (en_b),
        .Data_out (dout_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference: each enabled edge adds one step, capped at the terminal count.
    task automatic model_edge(input bit ea, input bit eb);
        if (ea) m_a = (m_a + 1 > MAX_A) ? MAX_A : m_a + 1;
        if (eb) m_b = (m_b + 1 > MAX_B) ? MAX_B : m_b + 1;
    endtask

    task automatic step(input bit ea, input bit eb, input string tag);
        @(negedge Clk);
        en_a = ea;
        en_b = eb;
        @(posedge Clk);
        model_edge(ea, eb);
        #1;
        check_eq({tag, "_a"}, {24'd0, dout_a}, m_a);
        check_eq({tag, "_b"}, {24'd0, dout_b}, m_b);
    endtask

    // Reset asserted between edges, held over one edge with Enable high, then
    // released with enough idle cycles for the synchronizer to let go.
    task automatic mid_reset(input string tag);
        @(negedge Clk);
        #3;
        Reset = 1'b1;
        #1;
        m_a = 0;
        m_b = 0;
        check_eq({tag, "_async_a"}, {24'd0, dout_a}, 0);
        check_eq({tag, "_async_b"}, {24'd0, dout_b}, 0);
        en_a = 1'b1;
        en_b = 1'b1;
        @(posedge Clk);
        #1;
        check_eq({tag, "_rst_wins"}, {24'd0, dout_a}, 0);
        @(negedge Clk);
        Reset = 1'b0;
        en_a  = 1'b0;
        en_b  = 1'b0;
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, {tag, "_sync"});
    endtask

    initial begin
        Reset = 1'b1;
        en_a  = 1'b0;
        en_b  = 1'b0;
        #5;
        check_eq("por_a", {24'd0, dout_a}, 0);
        check_eq("por_b", {24'd0, dout_b}, 0);
        check_eq("por_state", 32'(int'(dut_a.r_state)), 32'(int'(IDLE)));
        #7;
        Reset = 1'b0;

        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, "idle");
        check_eq("idle_state", 32'(int'(dut_a.r_state)), 32'(int'(IDLE)));

        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, "cont");
            check_eq("cont_val", {24'd0, dout_a}, i);
        end

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "hold");
        check_eq("hold_val", {24'd0, dout_a}, 5);
        step(1'b1, 1'b0, "reen");
        check_eq("reen_val", {24'd0, dout_a}, 6);

        mid_reset("pre_sat");
        for (int i = 1; i <= 105; i++) begin
            step(1'b1, (i <= 70), "sat");
            if (i == 100) check_eq("sat_edge100", {24'd0, dout_a}, 100);
        end
        check_eq("sat_hold", {24'd0, dout_a}, 100);
        check_eq("pow2_sat", {24'd0, dout_b}, 32'h40);
        check_eq("done_state", 32'(int'(dut_a.r_state)), 32'(int'(DONE)));

        mid_reset("pre42");
        for (int i = 0; i < 42; i++) step(1'b1, 1'b0, "to42");
        check_eq("at42", {24'd0, dout_a}, 42);
        mid_reset("mid42");
        step(1'b1, 1'b0, "restart");
        check_eq("restart_val", {24'd0, dout_a}, 1);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 1) begin
                mid_reset("rnd");
            end else begin
                step(($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0), "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
